// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO behind the UART receiver: parity check, circular store,
// host-paced pop, sticky drop flags and a saturating drop counter.
module uart_rx_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_parity,
  input  logic              rx_valid,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              parity_err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_ONE_C = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_ONE_P = ADDR_W'(1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [7:0]        r_rd_data_p1;
  logic              r_vld_p1;
  logic              r_overflow;
  logic              r_parity_err;
  logic [7:0]        r_err_cnt;

  logic              w_exp_par;
  logic              w_good;
  logic              w_bad_par;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;
  logic              w_ovf;
  logic [ADDR_W:0]   w_count_nxt;
  logic [7:0]        w_err_base;
  logic [7:0]        w_err_nxt;

  // Stage p0: parity check and write/pop/drop decisions from registered occupancy
  assign w_exp_par = PARITY_ODD ? ~^rx_data : ^rx_data;
  assign w_good    = rx_valid && (rx_parity == w_exp_par);
  assign w_bad_par = rx_valid && (rx_parity != w_exp_par);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == LP_DEPTH);
  assign w_pop     = rd_en && !w_empty;
  assign w_wr      = w_good && (!w_full || w_pop);
  assign w_ovf     = w_good && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_nxt = r_count + LP_ONE_C;
      2'b01:   w_count_nxt = r_count - LP_ONE_C;
      default: w_count_nxt = r_count;
    endcase
  end

  // A clear in the same cycle as a new drop clears first, so the new drop survives.
  always_comb begin
    w_err_base = err_clr ? 8'd0 : r_err_cnt;
    w_err_nxt  = w_err_base;
    if (w_bad_par || w_ovf) w_err_nxt = sat_inc(w_err_base);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= rx_data;
  end

  // Stage p1: registered pop output, occupancy, pointers and status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_data_p1 <= 8'd0;
      r_vld_p1     <= 1'b0;
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_cnt    <= 8'd0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + LP_ONE_P;
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + LP_ONE_P;
        r_rd_data_p1 <= r_mem[r_rd_ptr];
      end
      r_vld_p1     <= w_pop;
      r_count      <= w_count_nxt;
      r_overflow   <= (r_overflow   && !err_clr) || w_ovf;
      r_parity_err <= (r_parity_err && !err_clr) || w_bad_par;
      r_err_cnt    <= w_err_nxt;
    end
  end

  assign rd_data    = r_rd_data_p1;
  assign rd_valid   = r_vld_p1;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign parity_err = r_parity_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer (DEPTH=16, even parity).
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_parity;
  logic       rx_valid;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       parity_err;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_buffer #(.DEPTH(16), .ADDR_W(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_parity(rx_parity),
    .rx_valid(rx_valid), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .parity_err(parity_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    rx_data = d; rx_parity = p; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h41; rx_parity = 1'b0; rx_valid = 1'b1;
    rd_en = 1'b1; err_clr = 1'b0;

    // 1. Reset with activity held
    tick(); tick();
    rst = 1'b0; rx_valid = 1'b0; rd_en = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_overflow", overflow, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_err_cnt", err_cnt, 0);

    // 2. Basic write/pop
    push(8'h41, 1'b0);
    check("wr1_count", count, 1);
    check("wr1_empty", empty, 0);
    push(8'h43, 1'b1);
    check("wr2_count", count, 2);
    rd_en = 1'b1;
    tick();
    check("pop1_data", rd_data, 8'h41);
    check("pop1_valid", rd_valid, 1);
    check("pop1_count", count, 1);
    tick();
    check("pop2_data", rd_data, 8'h43);
    check("pop2_valid", rd_valid, 1);
    check("pop2_count", count, 0);
    rd_en = 1'b0;
    tick();
    check("pop_end_valid", rd_valid, 0);
    check("pop_end_empty", empty, 1);
    check("pop_end_data_hold", rd_data, 8'h43);

    // 3. Parity drop and clear
    push(8'h41, 1'b1);
    check("par_count", count, 0);
    check("par_flag", parity_err, 1);
    check("par_errcnt", err_cnt, 1);
    check("par_ovf", overflow, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_flag", parity_err, 0);
    check("clr_errcnt", err_cnt, 0);

    // 4. Fill, overflow, simultaneous write+pop on full, drain with wrap
    for (int i = 0; i < 16; i++) push(8'(i), ^(8'(i)));
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    push(8'h10, 1'b1);
    check("ovf_flag", overflow, 1);
    check("ovf_errcnt", err_cnt, 1);
    check("ovf_count", count, 16);
    check("ovf_parity_err", parity_err, 0);
    rd_en = 1'b1;
    push(8'h10, 1'b1);
    check("fullrw_data", rd_data, 8'h00);
    check("fullrw_valid", rd_valid, 1);
    check("fullrw_count", count, 16);
    check("fullrw_errcnt", err_cnt, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("drain_%0d", i), rd_data, 32'(i));
      check($sformatf("drain_vld_%0d", i), rd_valid, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);
    rd_en = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_ovf_errcnt", err_cnt, 0);

    // 5. Empty edge cases
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("empty_rd_valid", rd_valid, 0);
    check("empty_rd_hold", rd_data, 8'h10);
    rd_en = 1'b1;
    push(8'h55, 1'b0);
    check("empty_rw_count", count, 1);
    check("empty_rw_valid", rd_valid, 0);
    tick(); rd_en = 1'b0;
    check("empty_rw_data", rd_data, 8'h55);
    check("empty_rw_valid2", rd_valid, 1);
    check("empty_rw_count2", count, 0);

    // 6. Saturation and clear/error collision
    rx_data = 8'h41; rx_parity = 1'b1; rx_valid = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check("sat_254", err_cnt, 254);
    tick();
    check("sat_255", err_cnt, 255);
    for (int i = 0; i < 45; i++) tick();
    check("sat_hold", err_cnt, 255);
    check("sat_flag", parity_err, 1);
    check("sat_count", count, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0; rx_valid = 1'b0;
    check("collide_errcnt", err_cnt, 1);
    check("collide_flag", parity_err, 1);
    tick();
    check("collide_hold", err_cnt, 1);

    // Mid-operation reset discards contents
    push(8'h22, 1'b0);
    check("prerst_count", count, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_errcnt", err_cnt, 0);
    check("midrst_flag", parity_err, 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("midrst_no_pop", rd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
